// File: rtl/alu16_seq.sv
// 16-bit SM83 arithmetic sequencer: drives the shared 8-bit ALU for a low-byte
// pass then a high-byte pass, chaining carry/borrow through the ALU flags.
package alu_pkg;
  typedef struct packed {
    logic z;
    logic n;
    logic h;
    logic c;
  } flags_t;

  typedef enum logic [3:0] {
    ALU_PASS = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_ADC  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_SBC  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_OR   = 4'd7,
    ALU_CP   = 4'd8
  } alu_op_t;
endpackage

module alu16_seq
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    cmd,
  input  logic [15:0]   op_a,
  input  logic [15:0]   op_b,
  input  flags_t        flags_in,
  output logic          busy,
  output logic          done,
  output logic [15:0]   result,
  output flags_t        flags_out,
  output logic          alu_en,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output alu_op_t       alu_op,
  output flags_t        alu_flags,
  input  logic [7:0]    alu_res,
  input  flags_t        alu_flags_res
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_ADD16 = 2'b00,
    CMD_SPE8  = 2'b01,
    CMD_INC16 = 2'b10,
    CMD_DEC16 = 2'b11
  } cmd_e;

  state_e      state_q, state_d;
  cmd_e        cmd_q;
  logic [15:0] a_q, b_q;
  flags_t      flags_q;
  logic [7:0]  res_lo_q;
  flags_t      lo_flags_q;
  logic [15:0] result_q;
  flags_t      flags_out_q;
  flags_t      flags_fin;
  logic        load;

  assign load = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    alu_en    = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = ALU_PASS;
    alu_flags = '0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LO;
      end
      S_LO: begin
        busy      = 1'b1;
        alu_en    = 1'b1;
        alu_a     = a_q[7:0];
        alu_flags = flags_q;
        case (cmd_q)
          CMD_ADD16: begin alu_op = ALU_ADD; alu_b = b_q[7:0]; end
          CMD_SPE8:  begin alu_op = ALU_ADD; alu_b = b_q[7:0]; end
          CMD_INC16: begin alu_op = ALU_ADD; alu_b = 8'h01;    end
          default:   begin alu_op = ALU_SUB; alu_b = 8'h01;    end
        endcase
        state_d = S_HI;
      end
      S_HI: begin
        busy      = 1'b1;
        alu_en    = 1'b1;
        alu_a     = a_q[15:8];
        // Only the carry comes from the low pass; Z/N/H stay as latched.
        alu_flags = '{z: flags_q.z, n: flags_q.n, h: flags_q.h, c: lo_flags_q.c};
        case (cmd_q)
          CMD_ADD16: begin alu_op = ALU_ADC; alu_b = b_q[15:8];    end
          CMD_SPE8:  begin alu_op = ALU_ADC; alu_b = {8{b_q[7]}};  end
          CMD_INC16: begin alu_op = ALU_ADC; alu_b = 8'h00;        end
          default:   begin alu_op = ALU_SBC; alu_b = 8'h00;        end
        endcase
        state_d = S_DONE;
      end
      default: begin
        done    = 1'b1;
        state_d = start ? S_LO : S_IDLE;
      end
    endcase
  end

  always_comb begin
    flags_fin = flags_q;
    case (cmd_q)
      CMD_ADD16: flags_fin = '{z: flags_q.z, n: 1'b0, h: alu_flags_res.h, c: alu_flags_res.c};
      CMD_SPE8:  flags_fin = '{z: 1'b0, n: 1'b0, h: lo_flags_q.h, c: lo_flags_q.c};
      default:   flags_fin = flags_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= CMD_ADD16;
      a_q         <= '0;
      b_q         <= '0;
      flags_q     <= '0;
      res_lo_q    <= '0;
      lo_flags_q  <= '0;
      result_q    <= '0;
      flags_out_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        cmd_q   <= cmd_e'(cmd);
        a_q     <= op_a;
        b_q     <= op_b;
        flags_q <= flags_in;
      end
      if (state_q == S_LO) begin
        res_lo_q   <= alu_res;
        lo_flags_q <= alu_flags_res;
      end
      if (state_q == S_HI) begin
        result_q    <= {alu_res, res_lo_q};
        flags_out_q <= flags_fin;
      end
    end
  end

  assign result    = result_q;
  assign flags_out = flags_out_q;

endmodule

// File: tb/tb_alu16_seq.sv
// Bench for alu16_seq: behavioural 8-bit SM83 ALU attached to the ALU ports,
// table vectors, random ops vs. a 16-bit arithmetic model, handshake/reset cases.
module tb_alu16_seq;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  cmd;
  logic [15:0] op_a;
  logic [15:0] op_b;
  flags_t      flags_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  flags_t      flags_out;
  logic        alu_en;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  alu_op_t     alu_op;
  flags_t      alu_flags;
  logic [7:0]  alu_res;
  flags_t      alu_flags_res;

  int errors = 0;
  int checks = 0;

  alu16_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .op_a(op_a), .op_b(op_b),
    .flags_in(flags_in), .busy(busy), .done(done), .result(result),
    .flags_out(flags_out), .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_flags(alu_flags), .alu_res(alu_res),
    .alu_flags_res(alu_flags_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SM83 8-bit ALU
  int ia, ib, ci, r;
  always_comb begin
    ia = int'(alu_a);
    ib = int'(alu_b);
    ci = 0;
    r  = ia;
    alu_flags_res = alu_flags;
    case (alu_op)
      ALU_ADD, ALU_ADC: begin
        ci = (alu_op == ALU_ADC) ? int'(alu_flags.c) : 0;
        r  = ia + ib + ci;
        alu_flags_res.z = ((r % 256) == 0);
        alu_flags_res.n = 1'b0;
        alu_flags_res.h = ((ia % 16) + (ib % 16) + ci) > 15;
        alu_flags_res.c = r > 255;
      end
      ALU_SUB, ALU_SBC: begin
        ci = (alu_op == ALU_SBC) ? int'(alu_flags.c) : 0;
        r  = ia - ib - ci + 256;
        alu_flags_res.z = ((r % 256) == 0);
        alu_flags_res.n = 1'b1;
        alu_flags_res.h = (ia % 16) < ((ib % 16) + ci);
        alu_flags_res.c = ia < (ib + ci);
      end
      default: r = ia;
    endcase
    alu_res = 8'(r % 256);
  end

  // 16-bit reference: returns {flags, result}
  function automatic logic [19:0] ref_model(input logic [1:0] c, input logic [15:0] a,
                                            input logic [15:0] b, input logic [3:0] f);
    int x, y, e, se, s, res;
    logic [3:0] fl;
    x = int'(a);
    y = int'(b);
    res = 0;
    fl = f;
    case (c)
      2'b00: begin
        s   = x + y;
        res = s % 65536;
        fl  = {f[3], 1'b0, ((x % 4096) + (y % 4096)) > 4095, s > 65535};
      end
      2'b01: begin
        e   = y % 256;
        se  = (e >= 128) ? e - 256 : e;
        res = (x + se + 65536) % 65536;
        fl  = {2'b00, ((x % 16) + (e % 16)) > 15, ((x % 256) + e) > 255};
      end
      2'b10: res = (x + 1) % 65536;
      default: res = (x + 65535) % 65536;
    endcase
    return {fl, 16'(res)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] c, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] f, input logic [15:0] er, input logic [3:0] ef,
                        input string tag);
    @(negedge clk);
    start = 1'b1; cmd = c; op_a = a; op_b = b; flags_in = f;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " LO busy"}, 32'(busy), 32'd1);
    chk({tag, " LO alu_en"}, 32'(alu_en), 32'd1);
    chk({tag, " LO alu_b"}, 32'(alu_b), (c[1]) ? 32'h01 : 32'(b[7:0]));
    chk({tag, " LO alu_op"}, 32'(alu_op), (c == 2'b11) ? 32'(ALU_SUB) : 32'(ALU_ADD));
    @(negedge clk);
    chk({tag, " HI busy/done"}, {30'd0, busy, done}, 32'b10);
    @(negedge clk);
    chk({tag, " DONE busy/done/en"}, {29'd0, busy, done, alu_en}, 32'b010);
    chk({tag, " result"}, 32'(result), 32'(er));
    chk({tag, " flags"}, 32'(flags_out), 32'(ef));
  endtask

  typedef struct {
    logic [1:0]  c;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  f;
    logic [15:0] er;
    logic [3:0]  ef;
  } vec_t;

  vec_t vecs[6];
  logic [19:0] exp_v;
  int ndone;
  logic [15:0] cap;

  initial begin
    vecs[0] = '{2'b00, 16'h8A23, 16'h0605, 4'b1000, 16'h9028, 4'b1010};
    vecs[1] = '{2'b00, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011};
    vecs[2] = '{2'b01, 16'hFFF8, 16'h0008, 4'b1100, 16'h0000, 4'b0011};
    vecs[3] = '{2'b01, 16'h1000, 16'h00FF, 4'b0000, 16'h0FFF, 4'b0000};
    vecs[4] = '{2'b10, 16'h00FF, 16'h0000, 4'b1010, 16'h0100, 4'b1010};
    vecs[5] = '{2'b11, 16'h0000, 16'h0000, 4'b0101, 16'hFFFF, 4'b0101};

    rst_n = 1'b0; start = 1'b0; cmd = '0; op_a = '0; op_b = '0; flags_in = '0;
    repeat (2) @(negedge clk);
    chk("reset busy/done/en", {29'd0, busy, done, alu_en}, 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset flags", 32'(flags_out), 32'd0);
    chk("reset alu a/b/flags", {12'd0, alu_a, alu_b, 4'(alu_flags)}, 32'd0);
    chk("reset alu_op", 32'(alu_op), 32'(ALU_PASS));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle alu_en", 32'(alu_en), 32'd0);

    for (int unsigned i = 0; i < 6; i++)
      run_op(vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].er, vecs[i].ef, "vec");

    for (int unsigned i = 0; i < 40; i++) begin
      logic [1:0]  c;
      logic [15:0] a, b;
      logic [3:0]  f;
      c = 2'($urandom_range(0, 3));
      a = 16'($urandom);
      b = 16'($urandom);
      f = 4'($urandom);
      exp_v = ref_model(c, a, b, f);
      run_op(c, a, b, f, exp_v[15:0], exp_v[19:16], "rand");
    end

    // start pulsed during LO must be ignored
    @(negedge clk);
    start = 1'b1; cmd = 2'b00; op_a = 16'h1234; op_b = 16'h1111; flags_in = '0;
    @(negedge clk);
    start = 1'b1; op_a = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; cap = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (done) begin ndone++; cap = result; end
      @(negedge clk);
    end
    chk("LO start ignored: done count", 32'(ndone), 32'd1);
    chk("LO start ignored: result", 32'(cap), 32'h2345);

    // start held through DONE: next op launches without an IDLE cycle
    start = 1'b1; cmd = 2'b10; op_a = 16'h0FFF; op_b = '0; flags_in = 4'b0110;
    @(negedge clk);
    cmd = 2'b00; op_a = 16'h0F00; op_b = 16'h0100; flags_in = 4'b0000;
    @(negedge clk);
    chk("b2b c2 done", 32'(done), 32'd0);
    @(negedge clk);
    chk("b2b c3 done", 32'(done), 32'd1);
    chk("b2b op1 result", 32'(result), 32'h1000);
    chk("b2b op1 flags", 32'(flags_out), 32'b0110);
    @(negedge clk);
    start = 1'b0;
    chk("b2b c4 busy/done", {30'd0, busy, done}, 32'b10);
    @(negedge clk);
    chk("b2b c5 done", 32'(done), 32'd0);
    @(negedge clk);
    chk("b2b c6 done", 32'(done), 32'd1);
    chk("b2b op2 result", 32'(result), 32'h1000);
    chk("b2b op2 flags", 32'(flags_out), 32'b0010);

    // asynchronous reset during HI
    @(negedge clk);
    start = 1'b1; cmd = 2'b00; op_a = 16'h0101; op_b = 16'h0101; flags_in = '0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre-reset HI busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset busy/done/en", {29'd0, busy, done, alu_en}, 32'd0);
    chk("async reset result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int unsigned k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("post-reset no done", 32'(ndone), 32'd0);
    run_op(2'b00, 16'h0101, 16'h0101, 4'b0000, 16'h0202, 4'b0000, "post-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
